uart_prog_loader: RTL and testbench

- UART program loader upstream of the single-cycle MIPS core.
- Receives 8N1 serial frames and assembles little-endian 32-bit words.
- Writes each word into instruction memory or data memory through dedicated write ports.
- Holds the core in reset while programming, so that after loading the core restarts from PC 0.

---
 rtl/uart_prog_loader.sv | 159 +++++++++++++++
 tb/tb_uart_prog_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: receives 8N1 UART frames and writes 32-bit words into instruction or data memory while holding the core in reset
module uart_prog_loader #(
   parameter int CLKS_PER_BIT = 180,
   parameter int ADDR_W       = 14,
   parameter int TIMEOUT_CYC  = 2300000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              start_pg,
   input  logic              rx,
   output logic              prog_busy,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] prog_addr,
   output logic [31:0]       prog_data,
   output logic              done,
   output logic              error
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {IDLE, HDR, LEN_LO, LEN_HI, DATA, CHK, ERR} state_t;

   logic [2:0]        rx_sync;
   logic [2:0]        pg_sync;
   rx_state_t         rx_state, rx_next;
   logic [CW-1:0]     cnt;
   logic [2:0]        bit_idx;
   logic [7:0]        rx_byte;
   logic              half, full, rx_s, rx_fall, pg_rise;
   logic              byte_valid, frame_err;
   state_t            state, state_next;
   logic              sel_d, active, timeout;
   logic [15:0]       len, len_n;
   logic [ADDR_W-1:0] widx;
   logic [1:0]        bcnt;
   logic [23:0]       wbuf;
   logic [7:0]        csum;
   logic [TW-1:0]     to_cnt;

   assign rx_s    = rx_sync[1];
   assign rx_fall = rx_sync[2] & ~rx_sync[1];
   assign pg_rise = pg_sync[1] & ~pg_sync[2];
   assign half    = cnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign full    = cnt == CW'(CLKS_PER_BIT - 1);
   assign len_n   = {rx_byte, len[7:0]};
   assign active  = state inside {HDR, LEN_LO, LEN_HI, DATA, CHK};
   assign timeout = active && to_cnt == TW'(TIMEOUT_CYC - 1) && !byte_valid;

   // two-flop synchronisers plus a history flop for edge detection; rx history resets high (idle line)
   always_ff @(posedge clock or posedge rst)
      if (rst) begin
         rx_sync <= 3'b111;
         pg_sync <= 3'b000;
      end else begin
         rx_sync <= {rx_sync[1:0], rx};
         pg_sync <= {pg_sync[1:0], start_pg};
      end

   // receiver next state: start re-check at half bit, data and stop sampled every full bit
   always_comb begin
      rx_next    = rx_state;
      byte_valid = 1'b0;
      frame_err  = 1'b0;
      case (rx_state)
         R_IDLE:  rx_next = rx_fall ? R_START : R_IDLE;
         R_START: rx_next = !half ? R_START : rx_s ? R_IDLE : R_DATA;
         R_DATA:  rx_next = (full && bit_idx == 3'd7) ? R_STOP : R_DATA;
         R_STOP: begin
            rx_next    = full ? R_IDLE : R_STOP;
            byte_valid = full && rx_s;
            frame_err  = full && !rx_s;
         end
         default: rx_next = R_IDLE;
      endcase
   end

   // receiver state, bit timer and LSB-first shift register
   always_ff @(posedge clock or posedge rst)
      if (rst) begin
         rx_state <= R_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         rx_byte  <= '0;
      end else begin
         rx_state <= rx_next;
         cnt      <= (rx_next != rx_state || full) ? '0 : cnt + 1'b1;
         if (rx_state == R_DATA && full) begin
            rx_byte <= {rx_s, rx_byte[7:1]};
            bit_idx <= bit_idx + 1'b1;
         end
      end

   // loader next state; framing errors and timeouts abort any active frame
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    state_next = pg_rise ? HDR : IDLE;
         HDR:     if (byte_valid) state_next = (rx_byte == 8'hA5 || rx_byte == 8'h5A) ? LEN_LO : ERR;
         LEN_LO:  if (byte_valid) state_next = LEN_HI;
         LEN_HI:  if (byte_valid) state_next = ({1'b0, len_n} > (17'd1 << ADDR_W)) ? ERR : (len_n == 16'd0) ? CHK : DATA;
         DATA:    if (byte_valid && bcnt == 2'd3 && widx == ADDR_W'(len - 16'd1)) state_next = CHK;
         CHK:     if (byte_valid) state_next = (rx_byte == csum) ? IDLE : ERR;
         ERR:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (active && (frame_err || timeout)) state_next = ERR;
   end

   // loader state, frame bookkeeping and registered memory-write outputs
   always_ff @(posedge clock or posedge rst)
      if (rst) begin
         state     <= IDLE;
         prog_busy <= 1'b0;
         imem_we   <= 1'b0;
         dmem_we   <= 1'b0;
         prog_addr <= '0;
         prog_data <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
         sel_d     <= 1'b0;
         len       <= '0;
         widx      <= '0;
         bcnt      <= '0;
         wbuf      <= '0;
         csum      <= '0;
         to_cnt    <= '0;
      end else begin
         state     <= state_next;
         prog_busy <= state_next inside {HDR, LEN_LO, LEN_HI, DATA, CHK};
         imem_we   <= 1'b0;
         dmem_we   <= 1'b0;
         done      <= state == CHK && byte_valid && rx_byte == csum;
         to_cnt    <= (!active || byte_valid) ? '0 : to_cnt + 1'b1;
         if (state == IDLE && pg_rise) error <= 1'b0;
         else if (state_next == ERR) error <= 1'b1;
         if (byte_valid && state == HDR) begin
            sel_d <= rx_byte == 8'h5A;
            widx  <= '0;
            bcnt  <= '0;
            csum  <= '0;
         end
         if (byte_valid && state == LEN_LO) len[7:0] <= rx_byte;
         if (byte_valid && state == LEN_HI) len[15:8] <= rx_byte;
         if (byte_valid && state == DATA) begin
            csum <= csum ^ rx_byte;
            bcnt <= bcnt + 1'b1;
            wbuf <= {rx_byte, wbuf[23:8]};
            if (bcnt == 2'd3) begin
               prog_data <= {rx_byte, wbuf};
               prog_addr <= widx;
               imem_we   <= !sel_d;
               dmem_we   <= sel_d;
               widx      <= widx + 1'b1;
            end
         end
      end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed frames against a frame-level model of the loader with per-cycle write checking
module tb_uart_prog_loader;
   localparam int CPB = 16;
   localparam int AW  = 4;
   localparam int TO  = 500;

   logic          clock = 1'b0, rst = 1'b1, start_pg = 1'b0, rx = 1'b1;
   logic          prog_busy, imem_we, dmem_we, done, error;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_data;

   uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
      .clock(clock), .rst(rst), .start_pg(start_pg), .rx(rx), .prog_busy(prog_busy),
      .imem_we(imem_we), .dmem_we(dmem_we), .prog_addr(prog_addr), .prog_data(prog_data),
      .done(done), .error(error)
   );

   always #5 clock = ~clock;

   typedef struct {logic dm; logic [AW-1:0] addr; logic [31:0] data;} wr_t;
   wr_t           exp_q[$];
   wr_t           cur;
   logic [7:0]    fb[$];
   int            checks = 0, errors = 0;
   int            n_imem = 0, n_dmem = 0, n_done = 0;
   logic [AW-1:0] last_addr = '0;
   logic [31:0]   last_data = '0;
   logic          busy_d = 1'b0;
   logic          exp_err;
   int            exp_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clock) begin
      if (rst) begin
         last_addr = '0;
         last_data = '0;
         busy_d    = 1'b0;
      end else begin
         check("we_exclusive", 32'(imem_we & dmem_we), 32'd0);
         if (imem_we || dmem_we) begin
            if (exp_q.size() == 0) check("unexpected_write", 32'(prog_addr), 32'hFFFF_FFFF);
            else begin
               cur = exp_q.pop_front();
               check("write_mem", 32'(dmem_we), 32'(cur.dm));
               check("write_addr", 32'(prog_addr), 32'(cur.addr));
               check("write_data", prog_data, cur.data);
               last_addr = cur.addr;
               last_data = cur.data;
            end
            if (imem_we) n_imem++;
            else n_dmem++;
         end else begin
            check("hold_addr", 32'(prog_addr), 32'(last_addr));
            check("hold_data", prog_data, last_data);
         end
         if (done) begin
            n_done++;
            check("done_busy_low", 32'(prog_busy), 32'd0);
            check("done_busy_prev", 32'(busy_d), 32'd1);
            check("done_error_low", 32'(error), 32'd0);
         end
         busy_d = prog_busy;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic put(input logic v);
      rx = v;
      tick(CPB);
   endtask

   task automatic send_byte(input logic [7:0] b);
      put(1'b0);
      for (int i = 0; i < 8; i++) put(b[i]);
      put(1'b1);
   endtask

   task automatic send_all();
      foreach (fb[i]) send_byte(fb[i]);
   endtask

   task automatic start();
      start_pg = 1'b1;
      tick(4);
      start_pg = 1'b0;
      tick(4);
   endtask

   task automatic model_frame();
      int         n;
      logic [7:0] x;
      wr_t        w;
      exp_err  = 1'b1;
      exp_done = 0;
      if (fb.size() < 1 || !(fb[0] == 8'hA5 || fb[0] == 8'h5A)) return;
      if (fb.size() < 3) return;
      n = int'({fb[2], fb[1]});
      if (n > (1 << AW)) return;
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         if (fb.size() < 4 * i + 7) return;
         w.dm   = fb[0] == 8'h5A;
         w.addr = AW'(i);
         w.data = {fb[4*i+6], fb[4*i+5], fb[4*i+4], fb[4*i+3]};
         exp_q.push_back(w);
         x = x ^ fb[4*i+3] ^ fb[4*i+4] ^ fb[4*i+5] ^ fb[4*i+6];
      end
      if (fb.size() < 4 * n + 4) return;
      if (fb[4*n+3] == x) begin
         exp_err  = 1'b0;
         exp_done = 1;
      end
   endtask

   task automatic run(input string name);
      int d0, k;
      d0 = n_done;
      k  = 0;
      model_frame();
      send_all();
      while (prog_busy && k < 200) begin
         tick(1);
         k++;
      end
      tick(3);
      check({name, "_busy"}, 32'(prog_busy), 32'd0);
      check({name, "_error"}, 32'(error), 32'(exp_err));
      check({name, "_done"}, 32'(n_done - d0), 32'(exp_done));
      check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int         k;
      logic [7:0] x, b;
      tick(3);
      check("rst_busy", 32'(prog_busy), 32'd0);
      check("rst_we", 32'({imem_we, dmem_we}), 32'd0);
      check("rst_addr", 32'(prog_addr), 32'd0);
      check("rst_data", prog_data, 32'd0);
      check("rst_done_err", 32'({done, error}), 32'd0);
      rst = 1'b0;
      tick(2);

      start();
      check("start_busy", 32'(prog_busy), 32'd1);
      // the eight data bytes XOR to 0x2A
      fb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      run("imem_load");
      check("imem_count", 32'(n_imem), 32'd2);
      check("imem_last_addr", 32'(prog_addr), 32'd1);
      check("imem_last_data", prog_data, 32'hDEADBEEF);
      check("imem_done_count", 32'(n_done), 32'd1);

      start();
      fb = '{8'h5A, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'hFF};
      run("dmem_badchk");
      check("dmem_count", 32'(n_dmem), 32'd2);
      check("dmem_error_lit", 32'(error), 32'd1);
      check("dmem_no_done", 32'(n_done), 32'd1);

      start();
      fb = '{8'h33};
      run("bad_hdr");
      check("bad_hdr_no_writes", 32'(n_imem + n_dmem), 32'd4);

      start();
      check("err_cleared", 32'(error), 32'd0);
      fb = '{8'hA5, 8'h00, 8'h00, 8'h00};
      run("zero_len");
      check("zero_len_done_lit", 32'(n_done), 32'd2);
      check("zero_len_no_writes", 32'(n_imem + n_dmem), 32'd4);

      start();
      rx = 1'b0;
      tick(3);
      rx = 1'b1;
      tick(3 * CPB);
      check("glitch_no_err", 32'(error), 32'd0);
      check("glitch_busy", 32'(prog_busy), 32'd1);
      fb = '{8'hA5, 8'h01, 8'h00, 8'h11};
      model_frame();
      send_all();
      k = 0;
      while (!error && k < TO + 50) begin
         tick(1);
         k++;
      end
      check("timeout_error", 32'(error), 32'd1);
      check("timeout_window", 32'(k >= TO - CPB && k <= TO), 32'd1);
      check("timeout_busy", 32'(prog_busy), 32'd0);
      check("timeout_no_writes", 32'(n_imem + n_dmem), 32'd4);
      exp_q.delete();

      start();
      send_byte(8'hA5);
      send_byte(8'h02);
      send_byte(8'h00);
      send_byte(8'h01);
      send_byte(8'h02);
      put(1'b0);
      put(1'b1);
      put(1'b0);
      check("pre_rst_busy", 32'(prog_busy), 32'd1);
      rst = 1'b1;
      #1;
      check("async_rst_busy", 32'(prog_busy), 32'd0);
      check("async_rst_addr", 32'(prog_addr), 32'd0);
      check("async_rst_data", prog_data, 32'd0);
      check("async_rst_flags", 32'({imem_we, dmem_we, done, error}), 32'd0);
      rx = 1'b1;
      tick(2);
      rst = 1'b0;
      tick(2);
      start();
      fb = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
      run("after_rst");
      check("after_rst_count", 32'(n_imem), 32'd4);

      start();
      fb = '{8'hA5, 8'h11, 8'h00};
      run("len17");
      check("len17_no_writes", 32'(n_imem + n_dmem), 32'd6);

      start();
      fb = '{8'hA5, 8'h10, 8'h00};
      x  = 8'h00;
      for (int i = 0; i < 64; i++) begin
         b = 8'(i * 37 + 5);
         fb.push_back(b);
         x = x ^ b;
      end
      fb.push_back(x);
      run("len16");
      check("len16_count", 32'(n_imem), 32'd20);
      check("len16_last_addr", 32'(prog_addr), 32'd15);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
